// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-master memory arbiter: both master request
// channels plus the single memory-side channel.
interface mem_arbiter_if;
    logic        m0_rd_en_i;
    logic        m0_wr_en_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;

    logic        m1_rd_en_i;
    logic        m1_wr_en_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;

    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    // Arbiter side
    modport slave (
        input  m0_rd_en_i, m0_wr_en_i, m0_addr_i, m0_data_i,
        output m0_data_o, m0_ack_o,
        input  m1_rd_en_i, m1_wr_en_i, m1_addr_i, m1_data_i,
        output m1_data_o, m1_ack_o,
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    // Requester / memory-model side
    modport master (
        output m0_rd_en_i, m0_wr_en_i, m0_addr_i, m0_data_i,
        input  m0_data_o, m0_ack_o,
        output m1_rd_en_i, m1_wr_en_i, m1_addr_i, m1_data_i,
        input  m1_data_o, m1_ack_o,
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter with ack timeout.
// IDLE picks a winner, BUSY drives memory until ack/timeout, DONE pulses ack.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic [1:0]   grant_o,
    output logic         err_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        prio_m1_q, prio_m1_d;
    logic        win_q, win_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] m0_data_q, m0_data_d;
    logic [31:0] m1_data_q, m1_data_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [1:0]  grant_q, grant_d;
    logic        err_q, err_d;

    logic m0_req, m1_req, pick_m1, timeout, busy_end;

    assign m0_req   = bus.m0_rd_en_i | bus.m0_wr_en_i;
    assign m1_req   = bus.m1_rd_en_i | bus.m1_wr_en_i;
    assign pick_m1  = m1_req & (~m0_req | prio_m1_q);
    assign timeout  = (cnt_q == CW'(TIMEOUT - 1));
    assign busy_end = bus.mem_ack_i | timeout;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prio_m1_q   <= 1'b0;
            win_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_data_q   <= '0;
            m1_data_q   <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            grant_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_m1_q   <= prio_m1_d;
            win_q       <= win_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_data_q   <= m0_data_d;
            m1_data_q   <= m1_data_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
        end
    end

    // Next state and BUSY wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_req | m1_req) state_d = BUSY;
            end
            BUSY: begin
                if (busy_end) state_d = DONE;
                else          cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        prio_m1_d   = prio_m1_q;
        win_d       = win_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_data_d   = m0_data_q;
        m1_data_d   = m1_data_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        grant_d     = grant_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    win_d   = pick_m1;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    if (pick_m1) begin
                        mem_addr_d  = bus.m1_addr_i;
                        mem_wdata_d = bus.m1_data_i;
                        mem_wr_d    = bus.m1_wr_en_i;
                        mem_rd_d    = ~bus.m1_wr_en_i;
                    end else begin
                        mem_addr_d  = bus.m0_addr_i;
                        mem_wdata_d = bus.m0_data_i;
                        mem_wr_d    = bus.m0_wr_en_i;
                        mem_rd_d    = ~bus.m0_wr_en_i;
                    end
                end
            end
            BUSY: begin
                if (busy_end) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    err_d    = ~bus.mem_ack_i;
                    if (win_q) m1_ack_d = 1'b1;
                    else       m0_ack_d = 1'b1;
                    if (mem_rd_q) begin
                        if (win_q) m1_data_d = bus.mem_ack_i ? bus.mem_data_i : ERR_DATA;
                        else       m0_data_d = bus.mem_ack_i ? bus.mem_data_i : ERR_DATA;
                    end
                end
            end
            DONE: begin
                grant_d   = '0;
                prio_m1_d = ~win_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_rd_en_o = mem_rd_q;
    assign bus.mem_wr_en_o = mem_wr_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_data_o  = mem_wdata_q;
    assign bus.m0_data_o   = m0_data_q;
    assign bus.m1_data_o   = m1_data_q;
    assign bus.m0_ack_o    = m0_ack_q;
    assign bus.m1_ack_o    = m1_ack_q;
    assign grant_o         = grant_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus multi-cycle corner cases.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grant_o (grant_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m0_rd, m0_wr, m1_rd, m1_wr;
        logic [31:0] m0_a, m0_d, m1_a, m1_d;
        logic        ack;
        logic [31:0] rdata;
        logic        e_rd, e_wr;
        logic [1:0]  e_grant;
        logic        e_a0, e_a1, e_err;
        logic [31:0] e_addr, e_wdata, e_d0, e_d1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic m0_rd, input logic m0_wr, input logic m1_rd, input logic m1_wr,
        input logic [31:0] m0_a, input logic [31:0] m0_d,
        input logic [31:0] m1_a, input logic [31:0] m1_d,
        input logic ack, input logic [31:0] rdata,
        input logic e_rd, input logic e_wr, input logic [1:0] e_grant,
        input logic e_a0, input logic e_a1, input logic e_err,
        input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic [31:0] e_d0, input logic [31:0] e_d1);
        vec_t v;
        v.m0_rd = m0_rd; v.m0_wr = m0_wr; v.m1_rd = m1_rd; v.m1_wr = m1_wr;
        v.m0_a = m0_a; v.m0_d = m0_d; v.m1_a = m1_a; v.m1_d = m1_d;
        v.ack = ack; v.rdata = rdata;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_grant = e_grant;
        v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_err = e_err;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_rd_en_i = 0; bus.m0_wr_en_i = 0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_rd_en_i = 0; bus.m1_wr_en_i = 0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
        bus.mem_ack_i = 0; bus.mem_data_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_grant [7] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    logic       rr_a0    [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rr_a1    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        clear_inputs();

        // Per-cycle table: inputs driven at negedge, outputs checked just after posedge
        //          m0r m0w m1r m1w m0a        m0d           m1a        m1d           ack rdata         rd wr grant  a0 a1 er addr       wdata         d0            d1
        vecs.push_back(mk(1,0,0,0, 32'h10, 32'h0,        32'h0,  32'h0,        0, 32'h0,        1,0,2'b01, 0,0,0, 32'h10, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h10, 32'h0,        32'h0,  32'h0,        0, 32'h0,        1,0,2'b01, 0,0,0, 32'h10, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h10, 32'h0,        32'h0,  32'h0,        1, 32'h12345678, 0,0,2'b01, 1,0,0, 32'h10, 32'h0,        32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        0, 32'h0,        0,0,2'b00, 0,0,0, 32'h10, 32'h0,        32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        32'h20, 32'hCAFEF00D, 0, 32'h0,        0,1,2'b10, 0,0,0, 32'h20, 32'hCAFEF00D, 32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        32'h20, 32'hCAFEF00D, 1, 32'hBAD0BAD0, 0,0,2'b10, 0,1,0, 32'h20, 32'hCAFEF00D, 32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        0, 32'h0,        0,0,2'b00, 0,0,0, 32'h20, 32'hCAFEF00D, 32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        1, 32'hFFFFFFFF, 0,0,2'b00, 0,0,0, 32'h20, 32'hCAFEF00D, 32'h12345678, 32'h0));
        vecs.push_back(mk(1,1,0,0, 32'h30, 32'h5555AAAA, 32'h0,  32'h0,        0, 32'h0,        0,1,2'b01, 0,0,0, 32'h30, 32'h5555AAAA, 32'h12345678, 32'h0));
        vecs.push_back(mk(1,1,0,0, 32'h30, 32'h5555AAAA, 32'h0,  32'h0,        1, 32'h99999999, 0,0,2'b01, 1,0,0, 32'h30, 32'h5555AAAA, 32'h12345678, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        0, 32'h0,        0,0,2'b00, 0,0,0, 32'h30, 32'h5555AAAA, 32'h12345678, 32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h60, 32'h0,        32'h0,  32'h0,        0, 32'h0,        1,0,2'b01, 0,0,0, 32'h60, 32'h0,        32'h12345678, 32'h0));
        vecs.push_back(mk(1,0,1,0, 32'h60, 32'h0,        32'h70, 32'h0,        0, 32'h0,        1,0,2'b01, 0,0,0, 32'h60, 32'h0,        32'h12345678, 32'h0));
        vecs.push_back(mk(1,0,1,0, 32'h60, 32'h0,        32'h70, 32'h0,        1, 32'h60,       0,0,2'b01, 1,0,0, 32'h60, 32'h0,        32'h60,       32'h0));
        vecs.push_back(mk(0,0,1,0, 32'h0,  32'h0,        32'h70, 32'h0,        0, 32'h0,        0,0,2'b00, 0,0,0, 32'h60, 32'h0,        32'h60,       32'h0));
        vecs.push_back(mk(0,0,1,0, 32'h0,  32'h0,        32'h70, 32'h0,        0, 32'h0,        1,0,2'b10, 0,0,0, 32'h70, 32'h0,        32'h60,       32'h0));
        vecs.push_back(mk(0,0,1,0, 32'h0,  32'h0,        32'h70, 32'h0,        1, 32'h70,       0,0,2'b10, 0,1,0, 32'h70, 32'h0,        32'h60,       32'h70));
        vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        0, 32'h0,        0,0,2'b00, 0,0,0, 32'h70, 32'h0,        32'h60,       32'h70));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd",    {31'd0, bus.mem_rd_en_o}, 32'd0);
        chk("rst_wr",    {31'd0, bus.mem_wr_en_o}, 32'd0);
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_err",   {31'd0, err_o}, 32'd0);
        chk("rst_acks",  {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
        chk("rst_addr",  bus.mem_addr_o, 32'd0);
        chk("rst_d0",    bus.m0_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.m0_rd_en_i = vecs[i].m0_rd; bus.m0_wr_en_i = vecs[i].m0_wr;
            bus.m0_addr_i  = vecs[i].m0_a;  bus.m0_data_i  = vecs[i].m0_d;
            bus.m1_rd_en_i = vecs[i].m1_rd; bus.m1_wr_en_i = vecs[i].m1_wr;
            bus.m1_addr_i  = vecs[i].m1_a;  bus.m1_data_i  = vecs[i].m1_d;
            bus.mem_ack_i  = vecs[i].ack;   bus.mem_data_i = vecs[i].rdata;
            edge_sample();
            chk($sformatf("v%0d_rd", i),    {31'd0, bus.mem_rd_en_o}, {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_wr", i),    {31'd0, bus.mem_wr_en_o}, {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_grant", i), {30'd0, grant_o}, {30'd0, vecs[i].e_grant});
            chk($sformatf("v%0d_ack0", i),  {31'd0, bus.m0_ack_o}, {31'd0, vecs[i].e_a0});
            chk($sformatf("v%0d_ack1", i),  {31'd0, bus.m1_ack_o}, {31'd0, vecs[i].e_a1});
            chk($sformatf("v%0d_err", i),   {31'd0, err_o}, {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d_addr", i),  bus.mem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), bus.mem_data_o, vecs[i].e_wdata);
            chk($sformatf("v%0d_d0", i),    bus.m0_data_o, vecs[i].e_d0);
            chk($sformatf("v%0d_d1", i),    bus.m1_data_o, vecs[i].e_d1);
        end

        // Round-robin with both masters holding requests; memory acks at once
        do_reset();
        bus.m0_rd_en_i = 1; bus.m0_addr_i = 32'h100;
        bus.m1_rd_en_i = 1; bus.m1_addr_i = 32'h200;
        bus.mem_ack_i  = 1; bus.mem_data_i = 32'hA1;
        for (int e = 0; e < 7; e++) begin
            edge_sample();
            chk($sformatf("rr%0d_grant", e), {30'd0, grant_o}, {30'd0, rr_grant[e]});
            chk($sformatf("rr%0d_ack0", e),  {31'd0, bus.m0_ack_o}, {31'd0, rr_a0[e]});
            chk($sformatf("rr%0d_ack1", e),  {31'd0, bus.m1_ack_o}, {31'd0, rr_a1[e]});
        end
        chk("rr_d1", bus.m1_data_o, 32'hA1);

        // Timeout on a read: 16 BUSY cycles, then ack + err + ERR_DATA
        do_reset();
        bus.m0_rd_en_i = 1; bus.m0_addr_i = 32'h40;
        for (int e = 0; e < 16; e++) begin
            edge_sample();
            chk($sformatf("to_busy%0d", e),
                {29'd0, bus.mem_rd_en_o, bus.m0_ack_o, err_o}, 32'b100);
        end
        edge_sample();
        chk("to_ack0", {31'd0, bus.m0_ack_o}, 32'd1);
        chk("to_err",  {31'd0, err_o}, 32'd1);
        chk("to_rd",   {31'd0, bus.mem_rd_en_o}, 32'd0);
        chk("to_d0",   bus.m0_data_o, 32'hDEADBEEF);
        @(negedge clk);
        bus.m0_rd_en_i = 0;
        edge_sample();
        chk("to_idle", {28'd0, grant_o, bus.m0_ack_o, err_o}, 32'd0);

        // Reset asserted during BUSY aborts silently; held request re-served
        do_reset();
        bus.m1_wr_en_i = 1; bus.m1_addr_i = 32'h50; bus.m1_data_i = 32'h77;
        edge_sample();
        chk("rb_wr",    {31'd0, bus.mem_wr_en_o}, 32'd1);
        chk("rb_grant", {30'd0, grant_o}, 32'b10);
        @(negedge clk);
        rst_n = 0;
        bus.mem_ack_i = 1;
        #1;
        chk("rb_async_ctl", {27'd0, bus.mem_wr_en_o, bus.mem_rd_en_o, grant_o, err_o}, 32'd0);
        chk("rb_async_addr", bus.mem_addr_o, 32'd0);
        chk("rb_async_wdata", bus.mem_data_o, 32'd0);
        chk("rb_async_d0", bus.m0_data_o, 32'd0);
        edge_sample();
        chk("rb_noack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        bus.mem_ack_i = 0;
        edge_sample();
        chk("rb_regrant", {30'd0, grant_o}, 32'b10);
        chk("rb_rewr",    {31'd0, bus.mem_wr_en_o}, 32'd1);
        chk("rb_readdr",  bus.mem_addr_o, 32'h50);
        @(negedge clk);
        bus.mem_ack_i = 1;
        edge_sample();
        chk("rb_ack1", {31'd0, bus.m1_ack_o}, 32'd1);
        chk("rb_ack0", {31'd0, bus.m0_ack_o}, 32'd0);
        @(negedge clk);
        clear_inputs();
        edge_sample();
        chk("rb_idle", {30'd0, grant_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
